// File: rtl/char_segment.sv
// Character segmentation: builds a per-column white-pixel occupancy map inside the
// plate box over one frame, then scans it for column runs and publishes char slots.
module char_segment #(
  parameter int IMG_WIDTH_LINE = 1024,
  parameter int IMG_WIDTH_DATA = 24,
  parameter int MAX_CHARS      = 8,
  parameter int MIN_CHAR_W     = 4
) (
  input  logic                      pixelclk,
  input  logic                      reset,
  input  logic [IMG_WIDTH_DATA-1:0] i_binary,
  input  logic                      i_hs,
  input  logic                      i_vs,
  input  logic                      i_de,
  input  logic [11:0]               i_hcount,
  input  logic [11:0]               i_vcount,
  input  logic [11:0]               hcount_l,
  input  logic [11:0]               hcount_r,
  input  logic [11:0]               vcount_l,
  input  logic [11:0]               vcount_r,
  output logic                      o_char_valid,
  output logic [3:0]                o_char_num,
  output logic [MAX_CHARS*12-1:0]   o_char_left,
  output logic [MAX_CHARS*12-1:0]   o_char_right,
  output logic                      o_overflow
);

  localparam int              AW       = (IMG_WIDTH_LINE > 1) ? $clog2(IMG_WIDTH_LINE) : 1;
  localparam logic [AW-1:0]   CLR_LAST = AW'(IMG_WIDTH_LINE - 1);
  localparam logic [12:0]     LINE_LIM = 13'(IMG_WIDTH_LINE);
  localparam logic [11:0]     MIN_W    = 12'(MIN_CHAR_W);
  localparam logic [3:0]      SLOTS    = 4'(MAX_CHARS);

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_SCAN    = 3'd3,
    ST_PUBLISH = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic                     vs_q;
  logic [AW-1:0]            clr_cnt_q, clr_cnt_d;
  logic [11:0]              box_hl_q, box_hl_d, box_hr_q, box_hr_d;
  logic [11:0]              box_vl_q, box_vl_d, box_vr_q, box_vr_d;
  logic                     wr_en_q, wr_en_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d;
  logic                     wr_data_q, wr_data_d;
  logic                     rd_data_q;
  logic [12:0]              scan_cnt_q, scan_cnt_d;
  logic                     prev_q, prev_d;
  logic [11:0]              run_left_q, run_left_d;
  logic [3:0]               num_q, num_d;
  logic                     ovf_q, ovf_d;
  logic [MAX_CHARS*12-1:0]  slot_l_q, slot_l_d, slot_r_q, slot_r_d;
  logic                     valid_q, valid_d;
  logic [3:0]               num_out_q, num_out_d;
  logic                     ovf_out_q, ovf_out_d;
  logic [MAX_CHARS*12-1:0]  left_out_q, left_out_d, right_out_q, right_out_d;

  logic                     vs_fall_s;
  logic                     box_ok_s;
  logic                     pix_hit_s;
  logic [12:0]              span_s;
  logic [12:0]              scan_last_s;
  logic [12:0]              rd_col_s;
  logic [12:0]              cur_col_s;
  logic [AW-1:0]            rd_addr_s;
  logic                     scan_bit_s;
  logic [11:0]              run_right_s;
  logic [11:0]              run_w_s;
  logic                     unused_s;

  logic col_mem [IMG_WIDTH_LINE];

  assign unused_s  = i_hs;
  assign vs_fall_s = vs_q & ~i_vs;
  assign box_ok_s  = (box_hl_q <= box_hr_q) && (box_vl_q <= box_vr_q);
  assign pix_hit_s = i_de && (i_binary != '0)
                     && (i_hcount >= box_hl_q) && (i_hcount <= box_hr_q)
                     && (i_vcount >= box_vl_q) && (i_vcount <= box_vr_q)
                     && ({1'b0, i_hcount} < LINE_LIM);

  // Scan cycle k issues column hl+k and consumes the data of column hl+k-1;
  // the cycle at scan_last is the forced-0 close-out.
  assign span_s      = {1'b0, box_hr_q} - {1'b0, box_hl_q} + 13'd1;
  assign scan_last_s = box_ok_s ? (span_s + 13'd1) : 13'd0;
  assign rd_col_s    = {1'b0, box_hl_q} + scan_cnt_q;
  assign cur_col_s   = rd_col_s - 13'd1;
  assign rd_addr_s   = AW'(rd_col_s);
  assign scan_bit_s  = (scan_cnt_q != 13'd0) && (scan_cnt_q != scan_last_s)
                       && (cur_col_s < LINE_LIM) && rd_data_q;

  // Column map: registered write port, 1-cycle registered read port.
  always_ff @(posedge pixelclk) begin
    if (wr_en_q) begin
      col_mem[wr_addr_q] <= wr_data_q;
    end
    rd_data_q <= col_mem[rd_addr_s];
  end

  // Next-state, map writes, run detection and publish.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    box_hl_d    = box_hl_q;
    box_hr_d    = box_hr_q;
    box_vl_d    = box_vl_q;
    box_vr_d    = box_vr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = 1'b0;
    scan_cnt_d  = scan_cnt_q;
    prev_d      = prev_q;
    run_left_d  = run_left_q;
    num_d       = num_q;
    ovf_d       = ovf_q;
    slot_l_d    = slot_l_q;
    slot_r_d    = slot_r_q;
    valid_d     = 1'b0;
    num_out_d   = num_out_q;
    ovf_out_d   = ovf_out_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    run_right_s = 12'd0;
    run_w_s     = 12'd0;

    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = 1'b0;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = ST_WAIT_VS;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end

      ST_WAIT_VS: begin
        if (vs_fall_s) begin
          box_hl_d = hcount_l;
          box_hr_d = hcount_r;
          box_vl_d = vcount_l;
          box_vr_d = vcount_r;
          state_d  = ST_ACCUM;
        end else begin
          state_d  = ST_WAIT_VS;
        end
      end

      ST_ACCUM: begin
        if (pix_hit_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = AW'(i_hcount);
          wr_data_d = 1'b1;
        end else begin
          wr_en_d   = 1'b0;
        end
        if (vs_fall_s) begin
          scan_cnt_d = 13'd0;
          prev_d     = 1'b0;
          run_left_d = 12'd0;
          num_d      = 4'd0;
          ovf_d      = 1'b0;
          slot_l_d   = '0;
          slot_r_d   = '0;
          state_d    = ST_SCAN;
        end else begin
          state_d    = ST_ACCUM;
        end
      end

      ST_SCAN: begin
        prev_d = scan_bit_s;
        if (!prev_q && scan_bit_s) begin
          run_left_d = cur_col_s[11:0];
        end else begin
          run_left_d = run_left_q;
        end
        if (prev_q && !scan_bit_s) begin
          run_right_s = 12'(cur_col_s - 13'd1);
          run_w_s     = run_right_s - run_left_q + 12'd1;
          if (run_w_s >= MIN_W) begin
            if (num_q < SLOTS) begin
              for (int k = 0; k < MAX_CHARS; k++) begin
                if (num_q == 4'(k)) begin
                  slot_l_d[k*12 +: 12] = run_left_q;
                  slot_r_d[k*12 +: 12] = run_right_s;
                end else begin
                  slot_l_d[k*12 +: 12] = slot_l_q[k*12 +: 12];
                  slot_r_d[k*12 +: 12] = slot_r_q[k*12 +: 12];
                end
              end
              num_d = num_q + 4'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            num_d = num_q;
          end
        end else begin
          num_d = num_q;
        end
        // Outputs load on the edge entering PUBLISH so valid and data align.
        if (scan_cnt_q == scan_last_s) begin
          valid_d     = 1'b1;
          num_out_d   = num_d;
          ovf_out_d   = ovf_d;
          left_out_d  = slot_l_d;
          right_out_d = slot_r_d;
          state_d     = ST_PUBLISH;
        end else begin
          scan_cnt_d  = scan_cnt_q + 13'd1;
        end
      end

      ST_PUBLISH: begin
        clr_cnt_d = '0;
        state_d   = ST_CLEAR;
      end

      default: begin
        clr_cnt_d = '0;
        state_d   = ST_CLEAR;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      vs_q        <= 1'b0;
      clr_cnt_q   <= '0;
      box_hl_q    <= 12'd0;
      box_hr_q    <= 12'd0;
      box_vl_q    <= 12'd0;
      box_vr_q    <= 12'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 1'b0;
      scan_cnt_q  <= 13'd0;
      prev_q      <= 1'b0;
      run_left_q  <= 12'd0;
      num_q       <= 4'd0;
      ovf_q       <= 1'b0;
      slot_l_q    <= '0;
      slot_r_q    <= '0;
      valid_q     <= 1'b0;
      num_out_q   <= 4'd0;
      ovf_out_q   <= 1'b0;
      left_out_q  <= '0;
      right_out_q <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= i_vs;
      clr_cnt_q   <= clr_cnt_d;
      box_hl_q    <= box_hl_d;
      box_hr_q    <= box_hr_d;
      box_vl_q    <= box_vl_d;
      box_vr_q    <= box_vr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      scan_cnt_q  <= scan_cnt_d;
      prev_q      <= prev_d;
      run_left_q  <= run_left_d;
      num_q       <= num_d;
      ovf_q       <= ovf_d;
      slot_l_q    <= slot_l_d;
      slot_r_q    <= slot_r_d;
      valid_q     <= valid_d;
      num_out_q   <= num_out_d;
      ovf_out_q   <= ovf_out_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
    end
  end

  assign o_char_valid = valid_q;
  assign o_char_num   = num_out_q;
  assign o_overflow   = ovf_out_q;
  assign o_char_left  = left_out_q;
  assign o_char_right = right_out_q;

endmodule
